// File: rtl/simplerisc_pkg.sv
// ---------------------------------------------------------------------------
// simplerisc_pkg
// Shared definitions for the SimpleRISC core: register index width, data
// width, the architecturally special register indices and the basic types
// used across the register file and its scoreboard.
// ---------------------------------------------------------------------------
package simplerisc_pkg;

    localparam int REG_IDX_W = 4;
    localparam int DW        = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DW-1:0]        word_t;

    // r14 holds the stack pointer, r15 the return address written by call.
    localparam reg_idx_t SP_IDX = 4'd14;
    localparam reg_idx_t RA_IDX = 4'd15;

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Per-register outstanding-write counters. Issue increments the counter of
// its destination, writeback retires one outstanding write. Issue is refused
// when the destination counter is saturated, unless a retire to the same
// register frees a slot in the same cycle.
//
// Configuration macro: REGFILE_BYPASS_EN -- when defined, a read port whose
// register is retiring its last outstanding write this cycle is not reported
// busy (the data is forwarded by the register file).
//
// Ports:
//   clk            core clock, all updates on posedge
//   rst_n          synchronous active-low reset, clears every counter
//   wb_we_i        writeback write enable
//   wb_idx_i       writeback destination index
//   issue_valid_i  an instruction writing issue_rd_i is issuing
//   issue_rd_i     destination of the issuing instruction
//   rs1_idx_i      operand port 1 index
//   rs2_idx_i      operand port 2 index
//   busy1_o        operand 1 register has an outstanding write
//   busy2_o        operand 2 register has an outstanding write
//   issue_ready_o  destination counter can accept another write
// ---------------------------------------------------------------------------
module rf_scoreboard #(
    parameter int NREGS = 16,
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wb_we_i,
    input  logic [3:0] wb_idx_i,
    input  logic       issue_valid_i,
    input  logic [3:0] issue_rd_i,
    input  logic [3:0] rs1_idx_i,
    input  logic [3:0] rs2_idx_i,
    output logic       busy1_o,
    output logic       busy2_o,
    output logic       issue_ready_o
);
    import simplerisc_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];

    // A retire to the issuing register frees a slot even at saturation.
    assign issue_ready_o = (cnt_q[issue_rd_i] != CNT_MAX) ||
                           (wb_we_i && (wb_idx_i == issue_rd_i));

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            logic inc;
            logic dec;
            // NOTE: every comb output gets a default on entry so no path leaves it unassigned (no latch).
            cnt_d[i] = cnt_q[i];
            inc      = issue_valid_i && issue_ready_o && (issue_rd_i == reg_idx_t'(i));
            // A retire with no tracked write (e.g. call writing r15) leaves the counter at 0.
            dec      = wb_we_i && (wb_idx_i == reg_idx_t'(i)) && (cnt_q[i] != '0);
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: this array is small control state that must start clean, so it is reset; the data storage beside it likewise has defined reset values.
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        busy1_o = (cnt_q[rs1_idx_i] != '0);
        busy2_o = (cnt_q[rs2_idx_i] != '0);
`ifdef REGFILE_BYPASS_EN
        // The last outstanding write lands this cycle and is forwarded.
        if ((cnt_q[rs1_idx_i] == CNT_ONE) && wb_we_i && (wb_idx_i == rs1_idx_i)) begin
            busy1_o = 1'b0;
        end
        if ((cnt_q[rs2_idx_i] == CNT_ONE) && wb_we_i && (wb_idx_i == rs2_idx_i)) begin
            busy2_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/reg_file_unit.sv
// ---------------------------------------------------------------------------
// reg_file_unit
// Architectural register file of the SimpleRISC core, the receiving end of
// the writeback path. Sixteen registers, all writable (no hardwired zero);
// r14 resets to the stack pointer initial value. Two combinational operand
// read ports plus a dedicated r15 (return address) port, and a pending-write
// scoreboard (rf_scoreboard) so issue can stall on read-after-write hazards.
//
// Configuration macro: REGFILE_BYPASS_EN -- when defined, read ports forward
// the writeback data in the same cycle (write-first) and busy flags drop when
// the last outstanding write retires. When undefined, reads return stored
// state only and a same-cycle read of the written index sees the old value.
//
// Ports:
//   clk          core clock, all state updates on posedge
//   rst_n        synchronous active-low reset
//   wb_we        writeback write enable
//   WP           writeback destination index
//   WriteData    writeback data
//   rs1_addr     operand port 1 index
//   rs2_addr     operand port 2 index
//   rd1          operand port 1 data (combinational)
//   rd2          operand port 2 data (combinational)
//   ra_out       current r15 (combinational)
//   issue_valid  instruction writing issue_rd is issuing this cycle
//   issue_rd     destination of the issuing instruction
//   busy1        rs1_addr has an outstanding write
//   busy2        rs2_addr has an outstanding write
//   issue_ready  low when the counter for issue_rd is saturated
// ---------------------------------------------------------------------------
module reg_file_unit #(
    parameter int            NREGS   = 16,
    parameter int            DW      = simplerisc_pkg::DW,
    parameter logic [DW-1:0] SP_INIT = 'h0000_FFFC,
    parameter int            CNT_W   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_we,
    input  logic [3:0]    WP,
    input  logic [DW-1:0] WriteData,
    input  logic [3:0]    rs1_addr,
    input  logic [3:0]    rs2_addr,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [DW-1:0] ra_out,
    input  logic          issue_valid,
    input  logic [3:0]    issue_rd,
    output logic          busy1,
    output logic          busy2,
    output logic          issue_ready
);
    import simplerisc_pkg::*;

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_we) begin
            regs_d[WP] = WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (reg_idx_t'(i) == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd1    = regs_q[rs1_addr];
        rd2    = regs_q[rs2_addr];
        ra_out = regs_q[RA_IDX];
`ifdef REGFILE_BYPASS_EN
        if (wb_we && (WP == rs1_addr)) rd1    = WriteData;
        if (wb_we && (WP == rs2_addr)) rd2    = WriteData;
        if (wb_we && (WP == RA_IDX))   ra_out = WriteData;
`endif
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_we_i       (wb_we),
        .wb_idx_i      (WP),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .rs1_idx_i     (rs1_addr),
        .rs2_idx_i     (rs2_addr),
        .busy1_o       (busy1),
        .busy2_o       (busy2),
        .issue_ready_o (issue_ready)
    );

endmodule
